// File: rtl/tinker_mem_responder.sv
// Memory-side responder for the multicycle Tinker core: one fetch port and one
// load/store port share a byte-addressed store behind a req/ack handshake.
module tinker_mem_responder #(
  parameter int unsigned MEM_BYTES = 524288,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_data,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        d_ack,
  output logic [63:0] d_rdata,
  output logic        err,
  output logic        busy
);
  localparam int AW = $clog2(MEM_BYTES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]    r_state;
  logic [3:0]    r_cnt;
  logic          r_port_d;
  logic          r_we;
  logic [63:0]   r_addr;
  logic [63:0]   r_wdata;
  logic [7:0]    r_mem [MEM_BYTES] = '{default: 8'h00};

  logic          w_access;
  logic          w_oor;
  logic [64:0]   w_end;
  logic [AW-1:0] w_base;
  logic [63:0]   w_rd;

  assign busy     = (r_state != S_IDLE);
  assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
  assign w_base   = r_addr[AW-1:0];
  // 65-bit end address so a request near 2^64 cannot wrap back into range
  assign w_end    = {1'b0, r_addr} + (r_port_d ? 65'd8 : 65'd4);
  assign w_oor    = (w_end > 65'(MEM_BYTES));

  always_comb begin
    w_rd = '0;
    for (int i = 0; i < 8; i++) begin
      w_rd[8*i +: 8] = r_mem[w_base + AW'(i)];
    end
  end

  // Backing store has no reset so preloaded contents survive a core reset
  always_ff @(posedge clk) begin
    if (w_access && r_port_d && r_we && !w_oor) begin
      for (int i = 0; i < 8; i++) begin
        r_mem[w_base + AW'(i)] <= r_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= 4'd0;
      r_port_d <= 1'b0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_data  <= '0;
      d_rdata  <= '0;
      err      <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Data port has priority; the fetch request simply stays pending
          if (d_req) begin
            r_port_d <= 1'b1;
            r_we     <= d_we;
            r_addr   <= d_addr;
            r_wdata  <= d_wdata;
            r_cnt    <= 4'(LATENCY);
            r_state  <= S_WAIT;
          end else if (if_req) begin
            r_port_d <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= if_addr;
            r_cnt    <= 4'(LATENCY);
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_RESP;
            err     <= w_oor;
            if (r_port_d) begin
              d_ack <= 1'b1;
              if (!r_we) d_rdata <= w_oor ? 64'd0 : w_rd;
            end else begin
              if_ack  <= 1'b1;
              if_data <= w_oor ? 32'd0 : w_rd[31:0];
            end
          end
        end
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tinker_mem_responder.sv
// Scoreboarded bench for tinker_mem_responder: a byte-array reference model
// predicts every ack; a LATENCY=0 instance covers the zero-wait timing.
module tb_tinker_mem_responder;
  localparam int MB  = 524288;
  localparam int LAT = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        if_req, if_ack, d_req, d_we, d_ack, err, busy;
  logic [63:0] if_addr, d_addr, d_wdata, d_rdata;
  logic [31:0] if_data;

  logic        z_if_req, z_if_ack, z_d_req, z_d_we, z_d_ack, z_err, z_busy;
  logic [63:0] z_if_addr, z_d_addr, z_d_wdata, z_d_rdata;
  logic [31:0] z_if_data;

  tinker_mem_responder #(.MEM_BYTES(MB), .LATENCY(LAT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .err(err), .busy(busy)
  );

  tinker_mem_responder #(.MEM_BYTES(MB), .LATENCY(0)) dut0 (
    .clk(clk), .reset(reset),
    .if_req(z_if_req), .if_addr(z_if_addr), .if_ack(z_if_ack), .if_data(z_if_data),
    .d_req(z_d_req), .d_we(z_d_we), .d_addr(z_d_addr), .d_wdata(z_d_wdata),
    .d_ack(z_d_ack), .d_rdata(z_d_rdata), .err(z_err), .busy(z_busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          port_d;
    bit          store;
    logic [63:0] data;
    bit          err;
  } exp_t;
  exp_t q[$];

  logic [7:0] mdl [MB];

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit oor(logic [63:0] a, int sz);
    return ({1'b0, a} + 65'(sz)) > 65'(MB);
  endfunction

  function automatic logic [63:0] rd(logic [63:0] a, int sz);
    logic [63:0] r = '0;
    if (oor(a, sz)) return 64'd0;
    for (int i = 0; i < sz; i++) r[8*i +: 8] = mdl[a + 64'(i)];
    return r;
  endfunction

  function automatic exp_t predict(bit port_d, bit we, logic [63:0] a, logic [63:0] wd);
    exp_t e;
    int sz = port_d ? 8 : 4;
    e.port_d = port_d;
    e.store  = port_d && we;
    e.err    = oor(a, sz);
    e.data   = e.store ? 64'd0 : rd(a, sz);
    if (e.store && !e.err)
      for (int i = 0; i < 8; i++) mdl[a + 64'(i)] = wd[8*i +: 8];
    return e;
  endfunction

  // Scoreboard monitor
  always @(negedge clk) begin
    if (reset) begin
      chk("ack_in_reset", {62'd0, if_ack, d_ack}, 64'd0);
    end else if (if_ack || d_ack) begin
      exp_t e;
      chk("dual_ack", {63'd0, if_ack & d_ack}, 64'd0);
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got d_ack=%0b if_ack=%0b expected none", d_ack, if_ack);
      end else begin
        e = q.pop_front();
        chk("ack_port", {63'd0, d_ack}, {63'd0, e.port_d});
        chk("ack_err", {63'd0, err}, {63'd0, e.err});
        if (!e.store) begin
          if (e.port_d) chk("d_rdata", d_rdata, e.data);
          else          chk("if_data", {32'd0, if_data}, e.data);
        end
      end
    end
  end

  // One complete transaction on the main instance; chg alters d_addr/d_wdata after acceptance
  task automatic txn(bit port_d, bit we, logic [63:0] a, logic [63:0] wd, bit chg);
    int n;
    q.push_back(predict(port_d, we, a, wd));
    if (port_d) begin
      d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    end else begin
      if_req = 1'b1; if_addr = a;
    end
    for (n = 1; n <= 30; n++) begin
      @(negedge clk);
      if (chg && n == 1) begin
        d_addr = 64'h400; d_wdata = ~wd;
      end
      if (d_ack || if_ack) break;
    end
    d_req = 1'b0; if_req = 1'b0;
    chk("latency", 64'(n), 64'(LAT + 2));
    @(negedge clk);
  endtask

  initial begin
    int nd, ni, k, last, nz;
    logic [63:0] a;
    reset = 1'b1;
    if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
    z_if_req = 0; z_d_req = 0; z_d_we = 0; z_if_addr = 0; z_d_addr = 0; z_d_wdata = 0;
    repeat (2) @(negedge clk);
    chk("rst_acks", {62'd0, if_ack, d_ack}, 64'd0);
    chk("rst_if_data", {32'd0, if_data}, 64'd0);
    chk("rst_d_rdata", d_rdata, 64'd0);
    chk("rst_err_busy", {62'd0, err, busy}, 64'd0);
    chk("rst_busy0", {63'd0, z_busy}, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Store, load, offset fetch
    txn(1, 1, 64'h100, 64'h1122334455667788, 0);
    chk("store_err", {63'd0, err}, 64'd0);
    txn(1, 0, 64'h100, 64'd0, 0);
    chk("load_0x100", d_rdata, 64'h1122334455667788);
    txn(0, 0, 64'h104, 64'd0, 0);
    chk("fetch_0x104", {32'd0, if_data}, 64'h11223344);

    // Both ports requesting together
    q.push_back(predict(1, 0, 64'h100, 64'd0));
    q.push_back(predict(0, 0, 64'h104, 64'd0));
    d_req = 1; d_we = 0; d_addr = 64'h100; if_req = 1; if_addr = 64'h104;
    nd = 0; ni = 0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (d_ack && nd == 0) begin nd = n; d_req = 0; end
      if (if_ack) begin ni = n; break; end
    end
    d_req = 0; if_req = 0;
    @(negedge clk);
    chk("both_d_lat", 64'(nd), 64'(LAT + 2));
    chk("both_i_gap", 64'(ni - nd), 64'(LAT + 3));

    // Range boundaries
    txn(1, 1, 64'h7FFF0, 64'hA5A5_5A5A_0F0F_F0F0, 0);
    txn(1, 0, 64'h7FFF9, 64'd0, 0);
    chk("oor_load_err", {63'd0, err}, 64'd1);
    txn(1, 1, 64'h7FFF9, 64'hFFFF_FFFF_FFFF_FFFF, 0);
    txn(1, 0, 64'h7FFF0, 64'd0, 0);
    chk("oor_store_nowrite", d_rdata, 64'hA5A5_5A5A_0F0F_F0F0);
    txn(1, 0, 64'h7FFF8, 64'd0, 0);
    chk("edge_load_err", {63'd0, err}, 64'd0);
    txn(0, 0, 64'h7FFFC, 64'd0, 0);
    txn(0, 0, 64'h7FFFD, 64'd0, 0);
    txn(1, 0, 64'hFFFF_FFFF_FFFF_FFFC, 64'd0, 0);

    // Reset shortly after a store is accepted
    txn(1, 1, 64'h200, 64'h0123_4567_89AB_CDEF, 0);
    d_req = 1; d_we = 1; d_addr = 64'h200; d_wdata = 64'hDEAD_DEAD_DEAD_DEAD;
    @(negedge clk);
    d_req = 0;
    @(posedge clk);
    #1 reset = 1'b1;
    #1 chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_ack", {63'd0, d_ack}, 64'd0);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    txn(1, 0, 64'h200, 64'd0, 0);
    chk("rst_old_value", d_rdata, 64'h0123_4567_89AB_CDEF);

    // Request fields change after acceptance
    txn(1, 1, 64'h300, 64'h3333_2222_1111_0000, 1);
    txn(1, 0, 64'h300, 64'd0, 0);
    txn(1, 0, 64'h400, 64'd0, 0);
    chk("chg_0x400_clean", d_rdata, 64'd0);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      if ($urandom_range(0, 7) == 0) a = 64'(MB - 12 + $urandom_range(0, 12));
      else                          a = 64'($urandom_range(0, 16'h7FF));
      txn($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, a, {$urandom, $urandom}, 0);
    end

    // Zero-latency instance
    z_d_req = 1; z_d_we = 1; z_d_addr = 64'h2000; z_d_wdata = 64'hCAFE_F00D_DEAD_BEEF;
    nz = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (z_d_ack) begin nz = n; break; end
    end
    z_d_req = 0;
    chk("z_store_lat", 64'(nz), 64'd2);
    chk("z_store_err", {63'd0, z_err}, 64'd0);
    @(negedge clk);
    z_if_req = 1; z_if_addr = 64'h2000;
    k = 0; last = 0;
    for (int n = 1; n <= 40 && k < 3; n++) begin
      @(negedge clk);
      if (z_if_ack) begin
        k++;
        chk("z_fetch_data", {32'd0, z_if_data}, 64'hDEAD_BEEF);
        if (k == 1) chk("z_first_ack", 64'(n), 64'd2);
        else        chk("z_ack_gap", 64'(n - last), 64'd3);
        last = n;
      end
    end
    z_if_req = 0;
    chk("z_fetch_count", 64'(k), 64'd3);

    repeat (4) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
